// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padding constants, padder FSM states, word generator.
// Pure combinational helpers, no latency of their own.
// No flow control here; used by the padder and the compression core.
package sha256_pkg;

  localparam logic [31:0] SHA256_PAD_WORD = 32'h80000000;
  localparam int unsigned WORDS_PER_BLOCK = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_CAP  = 2'd2,
    EMIT    = 2'd3
  } padder_state_t;

  // Number of 512-bit blocks needed for n message words plus marker and 64-bit length.
  function automatic logic [31:0] blocks_for_words(input logic [31:0] n);
    return ((n + 32'd2) >> 4) + 32'd1;
  endfunction

  // Generated word for a position at or beyond the message body (p >= n).
  function automatic logic [31:0] pad_word(input logic [31:0] p,
                                           input logic [31:0] n,
                                           input logic [31:0] t);
    logic [63:0] bit_len;
    logic [31:0] result;
    bit_len = {32'd0, n} << 5;
    result  = 32'd0;
    if (p == n)
      result = SHA256_PAD_WORD;
    else if (p == t - 32'd2)
      result = bit_len[63:32];
    else if (p == t - 32'd1)
      result = bit_len[31:0];
    return result;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Reads a word-addressed message and streams it SHA-256 padded as 16-word blocks.
// Latency: first word 3 cycles after start (1 cycle when empty); 3 cycles/message word, 1/pad word.
// Backpressure: blk_word/blk_idx/blk_last hold while blk_valid && !blk_ready; no reads advance.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [LEN_W-1:0]  num_words,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [31:0]       blk_word,
  output logic [3:0]        blk_idx,
  output logic              blk_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = LEN_W + 1;

  padder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] msg_addr_q, msg_addr_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [PW-1:0]     t_q, t_d;
  logic [PW-1:0]     p_q, p_d;
  logic [PW-1:0]     p_nx;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       blk_word_d;
  logic              blk_valid_d;

  assign p_nx     = p_q + PW'(1);
  assign blk_idx  = p_q[3:0];
  assign blk_last = blk_valid && (p_q == t_q - PW'(1));
  assign done     = (state_q == IDLE);
  assign busy     = !done;

  // State and datapath registers; reset clears the job and the stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      msg_addr_q <= '0;
      n_q        <= '0;
      t_q        <= '0;
      p_q        <= '0;
      mem_addr   <= '0;
      blk_word   <= '0;
      blk_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_addr_q <= msg_addr_d;
      n_q        <= n_d;
      t_q        <= t_d;
      p_q        <= p_d;
      mem_addr   <= mem_addr_d;
      blk_word   <= blk_word_d;
      blk_valid  <= blk_valid_d;
    end
  end

  // Next-state logic: fetch message words through the 2-cycle memory, then generate padding.
  always_comb begin
    state_d     = state_q;
    msg_addr_d  = msg_addr_q;
    n_d         = n_q;
    t_d         = t_q;
    p_d         = p_q;
    mem_addr_d  = mem_addr;
    blk_word_d  = blk_word;
    blk_valid_d = blk_valid;
    case (state_q)
      IDLE: begin
        if (start) begin
          msg_addr_d = message_addr;
          n_d        = num_words;
          t_d        = PW'(blocks_for_words(32'(num_words)) * WORDS_PER_BLOCK);
          p_d        = '0;
          if (num_words != '0) begin
            mem_addr_d = message_addr;
            state_d    = RD_WAIT;
          end else begin
            // Empty message: block is marker, zeros and a zero length.
            blk_word_d  = pad_word(32'd0, 32'd0,
                                   blocks_for_words(32'd0) * WORDS_PER_BLOCK);
            blk_valid_d = 1'b1;
            state_d     = EMIT;
          end
        end
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        blk_word_d  = mem_read_data;
        blk_valid_d = 1'b1;
        state_d     = EMIT;
      end
      EMIT: begin
        if (blk_ready) begin
          if (p_q == t_q - PW'(1)) begin
            blk_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            p_d = p_nx;
            if (p_nx < {1'b0, n_q}) begin
              mem_addr_d  = msg_addr_q + ADDR_W'(p_nx);
              blk_valid_d = 1'b0;
              state_d     = RD_WAIT;
            end else begin
              blk_word_d = pad_word(32'(p_nx), 32'(n_q), 32'(t_q));
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: expected stream queued at start, compared on handshake.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] message_addr = '0;
  logic [15:0] num_words = '0;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data;
  logic        blk_valid;
  logic        blk_ready = 1'b1;
  logic [31:0] blk_word;
  logic [3:0]  blk_idx;
  logic        blk_last;
  logic        busy;
  logic        done;

  sha256_msg_padder #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .message_addr(message_addr),
    .num_words(num_words), .mem_addr(mem_addr), .mem_read_data(mem_read_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_word(blk_word),
    .blk_idx(blk_idx), .blk_last(blk_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory with one register stage: data is ready to be sampled on the 2nd edge after the address.
  logic [31:0] mem [0:65535];
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        last;
  } ent_t;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int tests = 0;
  int fails = 0;
  int stall_err = 0;
  int drop_err = 0;

  // Monitor: collect accepted words, and watch stream stability across stalls.
  ent_t prev_e;
  ent_t cur_e;
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      cur_e = {blk_word, blk_idx, blk_last};
      if (prev_v && !prev_r) begin
        if (!blk_valid) drop_err++;
        else if (cur_e !== prev_e) stall_err++;
      end
      if (blk_valid && blk_ready) obs_q.push_back(cur_e);
      prev_v = blk_valid;
      prev_r = blk_ready;
      prev_e = cur_e;
    end
  end

  function automatic ent_t model_word(int a, int n, int p);
    int t;
    longint bl;
    logic [15:0] ad;
    ent_t e;
    t  = ((n + 2) / 16 + 1) * 16;
    bl = longint'(n) * 32;
    ad = 16'(a + p);
    if (p < n)           e.w = mem[ad];
    else if (p == n)     e.w = 32'h80000000;
    else if (p == t - 2) e.w = bl[63:32];
    else if (p == t - 1) e.w = bl[31:0];
    else                 e.w = 32'h0;
    e.idx  = 4'(p % 16);
    e.last = (p == t - 1);
    return e;
  endfunction

  task automatic start_job(input int a, input int n);
    int t;
    t = ((n + 2) / 16 + 1) * 16;
    for (int p = 0; p < t; p++) exp_q.push_back(model_word(a, n, p));
    message_addr = 16'(a);
    num_words    = 16'(n);
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    message_addr = 16'h0BAD;
    num_words    = 16'h0777;
  endtask

  // Run until done, driving ready; report cycle of first valid and of completion (-1 on timeout).
  task automatic run_job(input bit rnd, input int budget, output int first_v, output int done_cyc);
    first_v  = -1;
    done_cyc = -1;
    blk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (blk_valid) first_v = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (first_v < 0 && blk_valid) first_v = c;
      if (done) begin
        done_cyc = c;
        break;
      end
      blk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    blk_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (blk_valid !== 1'b0) begin fails++; $display("FAIL reset_blk_valid got %b exp 0", blk_valid); end
    tests++; if (blk_word !== 32'h0) begin fails++; $display("FAIL reset_blk_word got %h exp 0", blk_word); end
    tests++; if (blk_idx !== 4'h0) begin fails++; $display("FAIL reset_blk_idx got %h exp 0", blk_idx); end
    tests++; if (blk_last !== 1'b0) begin fails++; $display("FAIL reset_blk_last got %b exp 0", blk_last); end
    tests++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    tests++; if (busy !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL reset_busy_done got %b%b exp 01", busy, done); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int f, d;
    ent_t e, o;
    for (int i = 0; i < 20; i++) mem[100 + i] = 32'(i + 1);
    start_job(100, 20);
    run_job(1'b0, 500, f, d);
    tests++; if (f != 2) begin fails++; $display("FAIL basic_first_valid got %0d exp 2", f); end
    tests++; if (d != 72) begin fails++; $display("FAIL basic_done_cycle got %0d exp 72", d); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL basic_missing got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL basic_word got %h/%h/%b exp %h/%h/%b", o.w, o.idx, o.last, e.w, e.idx, e.last); end end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL basic_extra got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_boundary();
    int f, d;
    ent_t e, o;
    for (int n = 13; n <= 14; n++) begin
      start_job(300, n);
      run_job(1'b0, 500, f, d);
      tests++; if (d < 0) begin fails++; $display("FAIL boundary_timeout n=%0d got %0d exp done", n, d); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); tests++;
        if (obs_q.size() == 0) begin fails++; $display("FAIL boundary_missing n=%0d got none exp %h", n, e); end
        else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL boundary_word n=%0d got %h/%h/%b exp %h/%h/%b", n, o.w, o.idx, o.last, e.w, e.idx, e.last); end end
      end
      tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL boundary_extra n=%0d got %0d exp 0", n, obs_q.size()); obs_q.delete(); end
    end
  endtask

  task automatic test_zero();
    int f, d;
    ent_t e, o;
    start_job(500, 0);
    run_job(1'b0, 200, f, d);
    tests++; if (f != 0) begin fails++; $display("FAIL zero_first_valid got %0d exp 0", f); end
    tests++; if (d != 16) begin fails++; $display("FAIL zero_done_cycle got %0d exp 16", d); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL zero_missing got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL zero_word got %h/%h/%b exp %h/%h/%b", o.w, o.idx, o.last, e.w, e.idx, e.last); end end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL zero_extra got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_backpressure();
    int f, d;
    ent_t e, o;
    stall_err = 0;
    drop_err  = 0;
    start_job(100, 20);
    run_job(1'b1, 3000, f, d);
    tests++; if (d < 0) begin fails++; $display("FAIL bp_timeout got %0d exp done", d); end
    tests++; if (stall_err != 0) begin fails++; $display("FAIL bp_stall_stable got %0d exp 0", stall_err); end
    tests++; if (drop_err != 0) begin fails++; $display("FAIL bp_valid_drop got %0d exp 0", drop_err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL bp_missing got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL bp_word got %h/%h/%b exp %h/%h/%b", o.w, o.idx, o.last, e.w, e.idx, e.last); end end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL bp_extra got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_start_ignored();
    int f, d;
    ent_t e, o;
    start_job(200, 14);
    for (int c = 0; c < 500 && obs_q.size() < 17; c++) begin @(posedge clk); #1; end
    tests++; if (obs_q.size() < 17) begin fails++; $display("FAIL ign_reach_emit got %0d exp 17", obs_q.size()); end
    message_addr = 16'd900;
    num_words    = 16'd3;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    run_job(1'b0, 500, f, d);
    repeat (10) @(posedge clk);
    #1;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL ign_done got %b exp 1", done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL ign_missing got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL ign_word got %h/%h/%b exp %h/%h/%b", o.w, o.idx, o.last, e.w, e.idx, e.last); end end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL ign_extra got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    int f, d;
    ent_t e, o;
    start_job(100, 20);
    for (int c = 0; c < 500 && obs_q.size() < 5; c++) begin @(posedge clk); #1; end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    tests++; if (blk_valid !== 1'b0) begin fails++; $display("FAIL rstmid_blk_valid got %b exp 0", blk_valid); end
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_done_busy got %b%b exp 10", done, busy); end
    tests++; if (blk_idx !== 4'h0 || mem_addr !== 16'h0) begin fails++; $display("FAIL rstmid_idx_addr got %h/%h exp 0/0", blk_idx, mem_addr); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    @(posedge clk); #1;
    start_job(200, 14);
    run_job(1'b0, 500, f, d);
    tests++; if (f != 2) begin fails++; $display("FAIL rstmid_first_valid got %0d exp 2", f); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL rstmid_missing got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL rstmid_word got %h/%h/%b exp %h/%h/%b", o.w, o.idx, o.last, e.w, e.idx, e.last); end end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL rstmid_extra got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_wrap();
    int f, d;
    ent_t e, o;
    mem[16'hFFFE] = 32'h11110000;
    mem[16'hFFFF] = 32'h22220000;
    mem[16'h0000] = 32'h33330000;
    start_job(32'hFFFE, 3);
    run_job(1'b0, 500, f, d);
    tests++; if (d < 0) begin fails++; $display("FAIL wrap_timeout got %0d exp done", d); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL wrap_missing got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL wrap_word got %h/%h/%b exp %h/%h/%b", o.w, o.idx, o.last, e.w, e.idx, e.last); end end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL wrap_extra got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {16'hC0DE, 16'(i)};
    test_reset();
    test_basic();
    test_boundary();
    test_zero();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
